// File: rtl/onehot_code_decoder.sv
// Binary channel code to registered one-hot select, held HOLD cycles, then one all-zero gap cycle.
// Optional per-channel enable mask and drop flag when ONEHOT_DEC_MASK_EN is defined.
module onehot_code_decoder #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned HOLD  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_code,
  output logic                  in_ready,
  output logic [(2**WIDTH)-1:0] sel,
  output logic                  sel_valid,
  output logic                  done,
  output logic                  busy
`ifdef ONEHOT_DEC_MASK_EN
  ,
  input  logic                  mask_wr,
  input  logic [(2**WIDTH)-1:0] mask_data,
  output logic                  drop
`endif
);

  localparam int unsigned N    = 2 ** WIDTH;
  localparam int unsigned CntW = $clog2(HOLD) + 1;
  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  if (HOLD < 1 || HOLD > 255) begin : g_hold_check
    $error("onehot_code_decoder: HOLD must be in 1..255");
  end

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [N-1:0]     sel_q, sel_d;
  logic             sel_valid_q, sel_valid_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             code_masked;

  assign in_ready = (state_q == StIdle) && !rst;
  assign accept   = in_valid && in_ready;

`ifdef ONEHOT_DEC_MASK_EN
  logic [N-1:0] mask_q, mask_d;
  logic         drop_q, drop_d;

  // The mask is sampled before this cycle's write lands, so a same-cycle write only affects later codes.
  assign code_masked = !mask_q[in_code];
  assign mask_d      = mask_wr ? mask_data : mask_q;
  assign drop_d      = accept && code_masked;
  assign drop        = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '1;
      drop_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
      drop_q <= drop_d;
    end
  end
`else
  assign code_masked = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          code_d = in_code;
          if (code_masked) begin
            state_d = StGap;
          end else begin
            state_d = StDrive;
            cnt_d   = HoldLoad;
          end
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          state_d = StGap;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are derived from the next state so they are registered alongside it.
    sel_d = '0;
    if (state_d == StDrive) begin
      sel_d = N'(1) << code_d;
    end
    sel_valid_d = (state_d == StDrive);
    done_d      = (state_d == StDrive) && (cnt_d == '0);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      code_q      <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign done      = done_q;
  assign busy      = busy_q;

  a_sel_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(sel_q));
  a_done_in_drive: assert property (@(posedge clk) disable iff (rst) done_q |-> sel_valid_q);
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt_q <= HoldLoad);

endmodule

// File: tb/tb_onehot_code_decoder.sv
// Bench for onehot_code_decoder: two instances (HOLD=4 and HOLD=1) against a timeline model.
// Mask checks are enabled when ONEHOT_DEC_MASK_EN is defined.
module tb_onehot_code_decoder;

`ifdef ONEHOT_DEC_MASK_EN
  localparam bit MaskEn = 1'b1;
`else
  localparam bit MaskEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = '0;
  logic       mask_wr = 1'b0;
  logic [7:0] mask_data = 8'hFF;

  logic       rdy4, sv4, done4, busy4, drop4;
  logic [7:0] sel4;
  logic       rdy1, sv1, done1, busy1, drop1;
  logic [7:0] sel1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  onehot_code_decoder #(.WIDTH(3), .HOLD(4)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_ready (rdy4),
    .sel      (sel4),
    .sel_valid(sv4),
    .done     (done4),
    .busy     (busy4)
`ifdef ONEHOT_DEC_MASK_EN
    ,
    .mask_wr  (mask_wr),
    .mask_data(mask_data),
    .drop     (drop4)
`endif
  );

  onehot_code_decoder #(.WIDTH(3), .HOLD(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_ready (rdy1),
    .sel      (sel1),
    .sel_valid(sv1),
    .done     (done1),
    .busy     (busy1)
`ifdef ONEHOT_DEC_MASK_EN
    ,
    .mask_wr  (mask_wr),
    .mask_data(mask_data),
    .drop     (drop1)
`endif
  );

`ifndef ONEHOT_DEC_MASK_EN
  assign drop4 = 1'b0;
  assign drop1 = 1'b0;
`endif

  // Model: k counts edges since the accepting edge (k=1 is the first cycle after accept).
  typedef struct packed {
    logic        active;
    logic        masked;
    logic [2:0]  code;
    logic [15:0] k;
  } mdl_t;

  mdl_t       m4 = '0;
  mdl_t       m1 = '0;
  logic [7:0] mdl_mask = 8'hFF;

  function automatic int last_busy_k(mdl_t m, int hold);
    return m.masked ? 1 : hold + 1;
  endfunction

  function automatic logic mdl_busy(mdl_t m, int hold);
    return m.active && (int'(m.k) <= last_busy_k(m, hold));
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int hold, logic r, logic v, logic [2:0] c,
                                    logic [7:0] mask);
    mdl_t n = m;
    if (r) begin
      n.active = 1'b0;
    end else if (v && !mdl_busy(m, hold)) begin
      n.active = 1'b1;
      n.k      = 16'd1;
      n.code   = c;
      n.masked = !mask[c];
    end else if (mdl_busy(m, hold)) begin
      n.k = m.k + 16'd1;
    end
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(string tag, mdl_t m, int hold, logic [7:0] s, logic sv, logic d, logic b,
                     logic r, logic dr);
    logic       drive;
    logic [7:0] exp_sel;
    drive   = m.active && !m.masked && (int'(m.k) <= hold);
    exp_sel = drive ? (8'd1 << m.code) : 8'd0;
    chk({tag, ".sel"}, 32'(s), 32'(exp_sel));
    chk({tag, ".sel_valid"}, 32'(sv), 32'(drive));
    chk({tag, ".done"}, 32'(d), 32'(drive && (int'(m.k) == hold)));
    chk({tag, ".busy"}, 32'(b), 32'(mdl_busy(m, hold)));
    chk({tag, ".in_ready"}, 32'(r), 32'(!rst && !mdl_busy(m, hold)));
    if (MaskEn) chk({tag, ".drop"}, 32'(dr), 32'(m.active && m.masked && m.k == 16'd1));
  endtask

  always @(posedge clk) begin
    m4 = mdl_step(m4, 4, rst, in_valid, in_code, mdl_mask);
    m1 = mdl_step(m1, 1, rst, in_valid, in_code, mdl_mask);
    if (rst) mdl_mask = 8'hFF;
    else if (MaskEn && mask_wr) mdl_mask = mask_data;
    #1;
    cmp("h4", m4, 4, sel4, sv4, done4, busy4, rdy4, drop4);
    cmp("h1", m1, 1, sel1, sv1, done1, busy1, rdy1, drop1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    int n;
    // Reset then idle
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_sel", 32'(sel4), 32'h0);
    chk("rst_busy", 32'(busy4), 32'h0);
    chk("rst_ready", 32'(rdy4), 32'h1);

    // Single code 5, HOLD=4
    in_valid = 1'b1;
    in_code  = 3'd5;
    step();
    in_valid = 1'b0;
    chk("one_sel_t1", 32'(sel4), 32'h20);
    chk("one_sv_t1", 32'(sv4), 32'h1);
    repeat (3) step();
    chk("one_done_t4", 32'(done4), 32'h1);
    chk("one_sel_t4", 32'(sel4), 32'h20);
    step();
    chk("one_sel_t5", 32'(sel4), 32'h0);
    chk("one_ready_t5", 32'(rdy4), 32'h0);
    step();
    chk("one_ready_t6", 32'(rdy4), 32'h1);
    idle(6);

    // Back-to-back with in_valid held: codes 0 then 7
    in_valid = 1'b1;
    in_code  = 3'd0;
    step();
    chk("b2b_first", 32'(sel4), 32'h01);
    in_code = 3'd7;
    n = 0;
    while (n < 20 && sel4 != 8'h80) begin
      step();
      n++;
    end
    chk("b2b_spacing", 32'(n), 32'd6);
    idle(8);

    // HOLD=1: code 3, next accept 3 cycles later
    in_valid = 1'b1;
    in_code  = 3'd3;
    step();
    chk("h1_sel", 32'(sel1), 32'h08);
    chk("h1_done", 32'(done1), 32'h1);
    step();
    chk("h1_gap", 32'(sel1), 32'h0);
    step();
    chk("h1_idle", 32'(sel1), 32'h0);
    step();
    chk("h1_reaccept", 32'(sel1), 32'h08);
    idle(8);

    // Reset mid-DRIVE, then a fresh code
    in_valid = 1'b1;
    in_code  = 3'd2;
    step();
    in_valid = 1'b0;
    chk("abort_sel", 32'(sel4), 32'h04);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_sel0", 32'(sel4), 32'h0);
    chk("abort_done0", 32'(done4), 32'h0);
    chk("abort_busy0", 32'(busy4), 32'h0);
    in_valid = 1'b1;
    in_code  = 3'd6;
    step();
    in_valid = 1'b0;
    chk("fresh_sel", 32'(sel4), 32'h40);
    idle(8);

`ifdef ONEHOT_DEC_MASK_EN
    // Masked code 4 dropped, then code 1 driven
    mask_wr   = 1'b1;
    mask_data = 8'hEF;
    step();
    mask_wr  = 1'b0;
    in_valid = 1'b1;
    in_code  = 3'd4;
    step();
    chk("mask_drop", 32'(drop4), 32'h1);
    chk("mask_sel0", 32'(sel4), 32'h0);
    in_code = 3'd1;
    step();
    chk("mask_drop_clr", 32'(drop4), 32'h0);
    chk("mask_ready", 32'(rdy4), 32'h1);
    step();
    in_valid = 1'b0;
    chk("mask_sel1", 32'(sel4), 32'h02);
    idle(8);
`endif

    // Randomized traffic
    repeat (3000) begin
      rst       = ($urandom_range(63) == 0);
      in_valid  = ($urandom_range(2) != 0);
      in_code   = 3'($urandom_range(7));
      mask_wr   = ($urandom_range(15) == 0);
      mask_data = 8'($urandom);
      step();
    end
    rst     = 1'b0;
    mask_wr = 1'b0;
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
